// File: rtl/prog_loader_pkg.sv
// Shared types and constants for the UART program loader.
// Controller and receiver state encodings live here so both files agree on them.
package prog_loader_pkg;

    typedef enum logic [1:0] {
        WAIT_SYNC,
        GET_LEN,
        GET_DATA,
        GET_CSUM
    } state_t;

    typedef enum logic [1:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_STOP
    } rx_state_t;

    localparam logic [7:0]  SYNC_BYTE   = 8'hA5;
    localparam int unsigned MAX_LEN     = 32;

    localparam logic [1:0]  ERR_NONE    = 2'b00;
    localparam logic [1:0]  ERR_FRAMING = 2'b01;
    localparam logic [1:0]  ERR_LENGTH  = 2'b10;
    localparam logic [1:0]  ERR_CSUM    = 2'b11;

endpackage

// File: rtl/uart_rx_8n1.sv
// 8N1 UART receiver: two-flop synchroniser, mid-bit sampling, LSB first.
// Emits a one-cycle rx_valid with the byte, or rx_ferr when the stop sample is low.
module uart_rx_8n1
    import prog_loader_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 434
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rx,
    output logic       rx_valid,
    output logic       rx_ferr,
    output logic [7:0] rx_data
);

    localparam int unsigned      CNT_W   = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] HALF_M1 = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] BIT_M1  = CNT_W'(CLKS_PER_BIT - 1);

    logic             rx_meta, rx_sync, rx_prev;
    rx_state_t        state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic [2:0]       bit_idx, bit_nxt;
    logic [7:0]       shift, shift_nxt;
    logic             valid_nxt, ferr_nxt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_meta  <= 1'b1;
            rx_sync  <= 1'b1;
            rx_prev  <= 1'b1;
            state    <= RX_IDLE;
            cnt      <= '0;
            bit_idx  <= '0;
            shift    <= '0;
            rx_valid <= 1'b0;
            rx_ferr  <= 1'b0;
        end else begin
            rx_meta  <= rx;
            rx_sync  <= rx_meta;
            rx_prev  <= rx_sync;
            state    <= state_nxt;
            cnt      <= cnt_nxt;
            bit_idx  <= bit_nxt;
            shift    <= shift_nxt;
            rx_valid <= valid_nxt;
            rx_ferr  <= ferr_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        bit_nxt   = bit_idx;
        shift_nxt = shift;
        valid_nxt = 1'b0;
        ferr_nxt  = 1'b0;
        case (state)
            RX_IDLE: begin
                if (rx_prev && !rx_sync) begin
                    state_nxt = RX_START;
                    cnt_nxt   = '0;
                end
            end
            RX_START: begin
                // A start bit that is gone by mid-bit was a glitch: drop it silently.
                if (cnt == HALF_M1) begin
                    cnt_nxt   = '0;
                    bit_nxt   = '0;
                    state_nxt = rx_sync ? RX_IDLE : RX_DATA;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            RX_DATA: begin
                if (cnt == BIT_M1) begin
                    cnt_nxt   = '0;
                    shift_nxt = {rx_sync, shift[7:1]};
                    bit_nxt   = bit_idx + 3'd1;
                    if (bit_idx == 3'd7) begin
                        state_nxt = RX_STOP;
                    end
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            RX_STOP: begin
                if (cnt == BIT_M1) begin
                    cnt_nxt   = '0;
                    state_nxt = RX_IDLE;
                    valid_nxt = rx_sync;
                    ferr_nxt  = !rx_sync;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            default: state_nxt = RX_IDLE;
        endcase
    end

    assign rx_data = shift;

endmodule

// File: rtl/prog_loader_uart.sv
// Serial program loader: decodes SYNC/LEN/payload/CSUM frames from the UART and
// streams payload bytes into CPU instruction memory, holding the CPU until a good load.
module prog_loader_uart
    import prog_loader_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 434,
    parameter int unsigned MEM_DEPTH    = 32
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rx,
    output logic       mem_we,
    output logic [4:0] mem_addr,
    output logic [7:0] mem_wdata,
    output logic       cpu_hold,
    output logic       load_done,
    output logic       load_ok,
    output logic [1:0] err_code
);

    localparam logic [7:0] LEN_LIMIT = 8'((MEM_DEPTH < MAX_LEN) ? MEM_DEPTH : MAX_LEN);

    logic       rx_valid, rx_ferr;
    logic [7:0] rx_data;

    uart_rx_8n1 #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx (
        .clk      (clk),
        .rst_n    (rst_n),
        .rx       (rx),
        .rx_valid (rx_valid),
        .rx_ferr  (rx_ferr),
        .rx_data  (rx_data)
    );

    state_t     state, state_nxt;
    logic [5:0] cnt, cnt_nxt, len, len_nxt;
    logic [7:0] csum, csum_nxt;
    logic       we_nxt, hold_nxt, done_nxt, ok_nxt;
    logic [4:0] addr_nxt;
    logic [7:0] wdata_nxt;
    logic [1:0] err_nxt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= WAIT_SYNC;
            cnt       <= '0;
            len       <= '0;
            csum      <= '0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            cpu_hold  <= 1'b0;
            load_done <= 1'b0;
            load_ok   <= 1'b0;
            err_code  <= ERR_NONE;
        end else begin
            state     <= state_nxt;
            cnt       <= cnt_nxt;
            len       <= len_nxt;
            csum      <= csum_nxt;
            mem_we    <= we_nxt;
            mem_addr  <= addr_nxt;
            mem_wdata <= wdata_nxt;
            cpu_hold  <= hold_nxt;
            load_done <= done_nxt;
            load_ok   <= ok_nxt;
            err_code  <= err_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        len_nxt   = len;
        csum_nxt  = csum;
        we_nxt    = 1'b0;
        addr_nxt  = mem_addr;
        wdata_nxt = mem_wdata;
        hold_nxt  = cpu_hold;
        done_nxt  = 1'b0;
        ok_nxt    = load_ok;
        err_nxt   = err_code;
        if (rx_ferr && state != WAIT_SYNC) begin
            err_nxt   = ERR_FRAMING;
            done_nxt  = 1'b1;
            state_nxt = WAIT_SYNC;
        end else if (rx_valid) begin
            case (state)
                WAIT_SYNC: begin
                    if (rx_data == SYNC_BYTE) begin
                        hold_nxt  = 1'b1;
                        ok_nxt    = 1'b0;
                        err_nxt   = ERR_NONE;
                        cnt_nxt   = '0;
                        csum_nxt  = '0;
                        state_nxt = GET_LEN;
                    end
                end
                GET_LEN: begin
                    if (rx_data == 8'd0 || rx_data > LEN_LIMIT) begin
                        err_nxt   = ERR_LENGTH;
                        done_nxt  = 1'b1;
                        state_nxt = WAIT_SYNC;
                    end else begin
                        len_nxt   = rx_data[5:0];
                        state_nxt = GET_DATA;
                    end
                end
                GET_DATA: begin
                    // SYNC_BYTE is ordinary data here; the length alone ends the payload.
                    we_nxt    = 1'b1;
                    addr_nxt  = cnt[4:0];
                    wdata_nxt = rx_data;
                    csum_nxt  = csum + rx_data;
                    cnt_nxt   = cnt + 6'd1;
                    if (cnt == len - 6'd1) begin
                        state_nxt = GET_CSUM;
                    end
                end
                GET_CSUM: begin
                    done_nxt  = 1'b1;
                    state_nxt = WAIT_SYNC;
                    if (rx_data == csum) begin
                        ok_nxt   = 1'b1;
                        hold_nxt = 1'b0;
                    end else begin
                        err_nxt = ERR_CSUM;
                    end
                end
                default: state_nxt = WAIT_SYNC;
            endcase
        end
    end

endmodule

// File: tb/tb_prog_loader_uart.sv
// Bench for prog_loader_uart: frames are described at the byte level and the
// expected memory writes / completion status are derived per frame from the frame rules.
module tb_prog_loader_uart;

    localparam int unsigned CPB = 8;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       rx = 1'b1;
    logic       mem_we, cpu_hold, load_done, load_ok;
    logic [4:0] mem_addr;
    logic [7:0] mem_wdata;
    logic [1:0] err_code;

    prog_loader_uart #(.CLKS_PER_BIT(CPB), .MEM_DEPTH(32)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .rx        (rx),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .cpu_hold  (cpu_hold),
        .load_done (load_done),
        .load_ok   (load_ok),
        .err_code  (err_code)
    );

    always #5 clk = ~clk;

    typedef logic [7:0] byteq_t[$];
    typedef struct packed { logic [4:0] addr; logic [7:0] data; } wr_t;
    typedef struct packed { logic ok; logic [1:0] err; logic hold; } dn_t;

    wr_t        wq[$];
    dn_t        dq[$];
    logic [7:0] seen_mem [32];
    int         total = 0;
    int         bad = 0;

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %02h expected %02h", name, act, exp);
        end
    endtask

    task automatic compare_loop();
        wr_t ew;
        dn_t ed;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                if (mem_we) begin
                    total++;
                    if (wq.size() == 0) begin
                        bad++;
                        $display("FAIL write_unexpected: got addr=%0d data=%02h expected no write", mem_addr, mem_wdata);
                    end else begin
                        ew = wq.pop_front();
                        if ({mem_addr, mem_wdata, cpu_hold} !== {ew.addr, ew.data, 1'b1}) begin
                            bad++;
                            $display("FAIL write: got addr=%0d data=%02h hold=%b expected addr=%0d data=%02h hold=1",
                                     mem_addr, mem_wdata, cpu_hold, ew.addr, ew.data);
                        end
                    end
                    seen_mem[mem_addr] = mem_wdata;
                end
                if (load_done) begin
                    total++;
                    if (dq.size() == 0) begin
                        bad++;
                        $display("FAIL done_unexpected: got load_done with err=%b expected none", err_code);
                    end else begin
                        ed = dq.pop_front();
                        if ({load_ok, err_code, cpu_hold} !== {ed.ok, ed.err, ed.hold}) begin
                            bad++;
                            $display("FAIL done: got ok=%b err=%b hold=%b expected ok=%b err=%b hold=%b",
                                     load_ok, err_code, cpu_hold, ed.ok, ed.err, ed.hold);
                        end
                    end
                end
            end
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop);
        @(negedge clk);
        rx = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            repeat (CPB) @(negedge clk);
        end
        rx = stop;
        repeat (CPB - 1) @(negedge clk);
        rx = 1'b1;
    endtask

    task automatic wait_drain(input string name);
        for (int c = 0; c < 400 && (wq.size() != 0 || dq.size() != 0); c++) @(negedge clk);
        total++;
        if (wq.size() != 0 || dq.size() != 0) begin
            bad++;
            $display("FAIL %s_timeout: got %0d writes %0d dones pending expected 0", name, wq.size(), dq.size());
        end
    endtask

    // ferr_at: index of the frame byte sent with a low stop bit (-1 for none).
    task automatic run_frame(input string name, input byteq_t fr, input int ferr_at);
        int         len;
        int         last;
        logic [7:0] sum;
        len  = int'(fr[1]);
        sum  = 8'h00;
        last = fr.size() - 1;
        if (ferr_at == 1) begin
            dq.push_back(dn_t'{1'b0, 2'b01, 1'b1});
            last = 1;
        end else if (len == 0 || len > 32) begin
            dq.push_back(dn_t'{1'b0, 2'b10, 1'b1});
            last = 1;
        end else begin
            for (int k = 0; k < len; k++) begin
                if (ferr_at < 0 || k + 2 < ferr_at) begin
                    wq.push_back(wr_t'{5'(k), fr[k+2]});
                    sum = sum + fr[k+2];
                end
            end
            if (ferr_at >= 0) begin
                dq.push_back(dn_t'{1'b0, 2'b01, 1'b1});
                last = ferr_at;
            end else if (sum == fr[len+2]) begin
                dq.push_back(dn_t'{1'b1, 2'b00, 1'b0});
            end else begin
                dq.push_back(dn_t'{1'b0, 2'b11, 1'b1});
            end
        end
        for (int i = 0; i <= last; i++) send_byte(fr[i], (i == ferr_at) ? 1'b0 : 1'b1);
        wait_drain(name);
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_we"},    {7'd0, mem_we},    8'h00);
        check({tag, "_addr"},  {3'd0, mem_addr},  8'h00);
        check({tag, "_wdata"}, mem_wdata,         8'h00);
        check({tag, "_hold"},  {7'd0, cpu_hold},  8'h00);
        check({tag, "_done"},  {7'd0, load_done}, 8'h00);
        check({tag, "_ok"},    {7'd0, load_ok},   8'h00);
        check({tag, "_err"},   {6'd0, err_code},  8'h00);
    endtask

    initial begin
        byteq_t     fr;
        int         len, kind, fa;
        logic [7:0] sum, b;
        fork
            compare_loop();
        join_none
        for (int i = 0; i < 32; i++) seen_mem[i] = 8'h00;
        repeat (3) @(negedge clk);
        check_reset_vals("por");
        rst_n = 1'b1;
        repeat (5) @(negedge clk);

        fr = {8'hA5, 8'h02, 8'h01, 8'h05, 8'h06};
        run_frame("good2", fr, -1);
        check("good2_mem0", seen_mem[0], 8'h01);
        check("good2_mem1", seen_mem[1], 8'h05);
        check("good2_ok",   {7'd0, load_ok},  8'h01);
        check("good2_err",  {6'd0, err_code}, 8'h00);
        check("good2_hold", {7'd0, cpu_hold}, 8'h00);

        fr = {8'hA5, 8'h02, 8'h01, 8'h05, 8'h07};
        run_frame("badsum", fr, -1);
        check("badsum_err",  {6'd0, err_code}, 8'h03);
        check("badsum_ok",   {7'd0, load_ok},  8'h00);
        check("badsum_hold", {7'd0, cpu_hold}, 8'h01);
        fr = {8'hA5, 8'h01, 8'h09, 8'h09};
        run_frame("recover", fr, -1);
        check("recover_hold", {7'd0, cpu_hold}, 8'h00);
        check("recover_mem0", seen_mem[0], 8'h09);

        fr = {8'hA5, 8'h00};
        run_frame("len0", fr, -1);
        check("len0_err", {6'd0, err_code}, 8'h02);
        fr = {8'hA5, 8'h21};
        run_frame("len33", fr, -1);
        check("len33_err", {6'd0, err_code}, 8'h02);
        check("len33_hold", {7'd0, cpu_hold}, 8'h01);

        fr = {8'hA5, 8'h02, 8'h3C, 8'h77, 8'hB3};
        run_frame("ferr", fr, 3);
        check("ferr_err",  {6'd0, err_code}, 8'h01);
        check("ferr_mem0", seen_mem[0], 8'h3C);
        check("ferr_mem1", seen_mem[1], 8'h05);

        send_byte(8'h5A, 1'b0);
        @(negedge clk);
        rx = 1'b0;
        repeat (3) @(negedge clk);
        rx = 1'b1;
        repeat (120) @(negedge clk);
        wait_drain("glitch");
        check("idle_err", {6'd0, err_code}, 8'h01);

        fr = {8'hA5, 8'h20};
        for (int i = 0; i < 32; i++) fr.push_back(8'hA5);
        fr.push_back(8'hA0);
        run_frame("full32", fr, -1);
        check("full32_mem31", seen_mem[31], 8'hA5);
        check("full32_ok", {7'd0, load_ok}, 8'h01);

        wq.push_back(wr_t'{5'd0, 8'h11});
        wq.push_back(wr_t'{5'd1, 8'h22});
        send_byte(8'hA5, 1'b1);
        send_byte(8'h04, 1'b1);
        send_byte(8'h11, 1'b1);
        send_byte(8'h22, 1'b1);
        repeat (4) @(negedge clk);
        wait_drain("prereset");
        rst_n = 1'b0;
        #1;
        check_reset_vals("midrst");
        wq.delete();
        dq.delete();
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        fr = {8'hA5, 8'h03, 8'h10, 8'h20, 8'h30, 8'h60};
        run_frame("postrst", fr, -1);
        check("postrst_mem2", seen_mem[2], 8'h30);

        for (int it = 0; it < 12; it++) begin
            kind = int'($urandom_range(0, 3));
            if ($urandom_range(0, 1) == 1) begin
                b = 8'($urandom_range(0, 255));
                if (b == 8'hA5) b = 8'h00;
                send_byte(b, 1'b1);
            end
            if (kind == 3) begin
                len = ($urandom_range(0, 1) == 1) ? 0 : int'($urandom_range(33, 255));
                fr = {8'hA5, 8'(len)};
                run_frame("rnd_len", fr, -1);
            end else begin
                len = int'($urandom_range(1, 12));
                fr = {8'hA5, 8'(len)};
                sum = 8'h00;
                for (int k = 0; k < len; k++) begin
                    b = 8'($urandom_range(0, 255));
                    fr.push_back(b);
                    sum = sum + b;
                end
                fr.push_back((kind == 1) ? sum + 8'(1 + $urandom_range(0, 254)) : sum);
                fa = (kind == 2) ? int'($urandom_range(1, len + 2)) : -1;
                run_frame("rnd_frame", fr, fa);
            end
        end

        repeat (10) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/prog_loader_uart.md
# prog_loader_uart

Serial program loader that sits directly upstream of the accumulator CPU core. It receives a framed program image over a UART line (8N1, LSB first) and streams each payload byte out as a one-cycle instruction-memory write. The outputs are write-enable, 5-bit address and 8-bit data, matching the CPU's memory-write port. It holds the CPU in write mode for the whole load and reports completion, checksum status and errors.

## Interface
- CLKS_PER_BIT, 434, clock cycles per UART bit (50 MHz / 115200); minimum 4
- MEM_DEPTH, 32, instruction-memory depth; address width is 5
- clk  input  1  system clock, all logic on rising edge
- rst_n  input  1  asynchronous active-low reset
- rx  input  1  asynchronous UART line, idle high
- mem_we  output  1  one-cycle write strobe per payload byte
- mem_addr  output  5  write address
- mem_wdata  output  8  write data
- cpu_hold  output  1  high while a load is in progress or the last load failed; drives CPU write mode
- load_done  output  1  one-cycle pulse at the end of every frame, good or bad
- load_ok  output  1  level; 1 after a frame with a good checksum, cleared at the next sync byte
- err_code  output  2  00 none, 01 framing, 10 bad length, 11 checksum; holds until the next sync byte

## Operation
- Frame format: SYNC (0xA5), LEN (1..32), LEN payload bytes, CSUM.
- CSUM is the 8-bit sum of the payload bytes, mod 256.
- Payload byte k goes to address k (0..LEN-1).
- rx is synchronised through 2 flops before any use.
- UART RX path:
  - A falling edge on the synchronised line starts the bit timer.
  - At CLKS_PER_BIT/2 the line must still be low; otherwise it is a false start and the receiver returns to idle with no error.
  - 8 data bits are sampled every CLKS_PER_BIT, LSB first, followed by the stop sample.
  - Stop sample = 1 gives an rx_valid pulse with the byte. Stop sample = 0 gives an rx_ferr pulse and no byte.
- Controller FSM: WAIT_SYNC, GET_LEN, GET_DATA, GET_CSUM.
- WAIT_SYNC:
  - Non-0xA5 bytes are ignored.
  - On 0xA5: cpu_hold=1, load_ok=0, err_code=00, byte counter=0, checksum=0; go to GET_LEN.
- GET_LEN:
  - LEN=0 or LEN>32: err_code=10, load_done pulse, go to WAIT_SYNC.
  - Otherwise latch LEN and go to GET_DATA.
- GET_DATA:
  - Each byte: mem_we=1, mem_addr=counter, mem_wdata=byte; checksum += byte; counter++.
  - After byte LEN-1, go to GET_CSUM.
  - 0xA5 inside the payload is data; there is no resync.
- GET_CSUM:
  - Match: load_ok=1, cpu_hold=0.
  - Mismatch: err_code=11, cpu_hold stays 1.
  - Either case: load_done pulse, go to WAIT_SYNC.
- Framing error in any state other than WAIT_SYNC: err_code=01, load_done pulse, go to WAIT_SYNC. A framing error in WAIT_SYNC is ignored.
- After any error, cpu_hold remains 1 until a later frame completes with a good checksum.
- Bytes already written by an aborted frame are not rolled back.

## Timing
- Reset values: mem_we 0, mem_addr 0, mem_wdata 0, cpu_hold 0, load_done 0, load_ok 0, err_code 00, FSM in WAIT_SYNC, RX idle.
- rx_valid is asserted in the cycle after the stop-bit mid-sample. The end-to-end delay from the rx falling edge is 2 + 9.5*CLKS_PER_BIT cycles, ±1.
- All controller outputs are registered and update in the cycle after rx_valid or rx_ferr.
- mem_we is high for exactly 1 cycle. mem_addr and mem_wdata are stable in that cycle and hold their values afterwards.
- cpu_hold rises with the cycle following SYNC's rx_valid, i.e. before the first mem_we. It falls in the same cycle as the good load_done.
- Back-to-back frames with zero idle time between stop and start bits are supported.
- Reset mid-frame: all state clears immediately. The next frame must begin with SYNC.

## Structure
- Package prog_loader_pkg holds:
  - FSM state enum
  - SYNC_BYTE = 8'hA5
  - MAX_LEN = 32
  - err_code constants
- Sub-module uart_rx_8n1 contains the synchroniser, bit timer, shift register and rx_valid/rx_ferr/rx_data outputs. It is parameterised by CLKS_PER_BIT.
- Top module prog_loader_uart contains the frame FSM, counter, checksum and output registers.

## Test plan
All scenarios use CLKS_PER_BIT=8.
- Frame A5 02 01 05 06 -> writes (0,01) then (1,05), load_done pulse, load_ok=1, err_code=00, cpu_hold low after done.
- Frame A5 02 01 05 07 -> both writes occur, err_code=11, load_ok=0, cpu_hold stays 1; a following good frame clears it to 0.
- Frame A5 00 and frame A5 21 -> no mem_we, err_code=10, load_done pulse, FSM back in WAIT_SYNC.
- Stop bit forced low on the 2nd payload byte -> only address 0 written, err_code=01; a 3-cycle low glitch on idle rx produces no byte and no error.
- Frame A5 20 followed by 32 bytes 0xA5 and CSUM 0xA0 -> 32 writes to addresses 0..31 with data A5, load_ok=1.
- rst_n pulsed low mid-payload -> all outputs return to reset values; the next full frame loads correctly.
